wb_arbiter: RTL and testbench

Writeback arbiter between the execution units and the architectural register file. It accepts results from `NUM_SRC` functional units over independent valid/ready channels and buffers them in small per-source FIFOs. It grants one result per cycle round-robin and drives the register file's single synchronous write port (`we`, `waddr`, `rd`) from a registered output stage.

---
 rtl/wb_arbiter_pkg.sv | 15 +
 rtl/wb_arbiter_if.sv | 32 +++
 rtl/wb_fifo.sv | 77 +++++++
 rtl/wb_arbiter.sv | 117 +++++++++++
 tb/tb_wb_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// Constants and helpers shared by the writeback arbiter and the register file.
package wb_arbiter_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_DEPTH = 32;
    localparam int unsigned REG_AW    = 5;

    // (base + offs) mod n, valid while base < n and offs <= n.
    function automatic int unsigned rr_wrap(int unsigned base, int unsigned offs, int unsigned n);
        int unsigned s;
        s = base + offs;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Producer channels and register-file write port of the writeback arbiter.
interface wb_arbiter_if
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned WIDTH   = XLEN,
    parameter int unsigned AW      = REG_AW
);

    logic                     flush;
    logic [NUM_SRC-1:0]       src_valid;
    logic [NUM_SRC-1:0]       src_ready;
    logic [NUM_SRC*AW-1:0]    src_waddr;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic                     we;
    logic [AW-1:0]            waddr;
    logic [WIDTH-1:0]         rd;
    logic                     busy;

    // master: the arbiter, which masters the register-file write port.
    modport master (
        input  flush, src_valid, src_waddr, src_data,
        output src_ready, we, waddr, rd, busy
    );

    // slave: producers and register file around the arbiter.
    modport slave (
        output flush, src_valid, src_waddr, src_data,
        input  src_ready, we, waddr, rd, busy
    );

endinterface

// File: rtl/wb_fifo.sv
// Small circular-buffer FIFO with occupancy count, async reset and sync clear.
module wb_fifo #(
    parameter  int unsigned WIDTH  = 8,
    parameter  int unsigned QDEPTH = 2,
    localparam int unsigned CW     = $clog2(QDEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam int unsigned PW = $clog2(QDEPTH);

    logic [WIDTH-1:0] mem_q [QDEPTH];
    logic [WIDTH-1:0] mem_d [QDEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(QDEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clr_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wptr_q] = wdata_i;
                wptr_d        = wptr_q + PW'(1);
            end
            if (do_pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(QDEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: per-source FIFOs feeding one registered register-file write port.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned WIDTH   = XLEN,
    parameter int unsigned DEPTH   = REG_DEPTH,
    parameter int unsigned QDEPTH  = 2
) (
    input logic          clk,
    input logic          rst,
    wb_arbiter_if.master bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = AW + WIDTH;
    localparam int unsigned RW = $clog2(NUM_SRC);
    localparam int unsigned CW = $clog2(QDEPTH + 1);

    logic [NUM_SRC-1:0] push, pop, full, empty, ready;
    logic [EW-1:0]      head  [NUM_SRC];
    logic [CW-1:0]      count [NUM_SRC];

    logic               gnt_valid;
    logic [RW-1:0]      gnt_idx;
    logic [RW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               we_q, we_d;
    logic [AW-1:0]      waddr_q, waddr_d;
    logic [WIDTH-1:0]   rd_q, rd_d;
    logic               fifo_busy;

    // Writes to x0 complete the handshake but are never enqueued.
    always_comb begin
        ready = '0;
        push  = '0;
        pop   = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            ready[i] = ~full[i] & ~bus.flush;
            push[i]  = bus.src_valid[i] & ready[i] & (bus.src_waddr[i*AW +: AW] != '0);
            pop[i]   = gnt_valid & (gnt_idx == RW'(i)) & ~bus.flush;
        end
    end

    for (genvar g = 0; g < int'(NUM_SRC); g++) begin : gen_fifo
        wb_fifo #(
            .WIDTH  (EW),
            .QDEPTH (QDEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .clr_i   (bus.flush),
            .push_i  (push[g]),
            .pop_i   (pop[g]),
            .wdata_i ({bus.src_waddr[g*AW +: AW], bus.src_data[g*WIDTH +: WIDTH]}),
            .rdata_o (head[g]),
            .full_o  (full[g]),
            .empty_o (empty[g]),
            .count_o (count[g])
        );
    end

    // First non-empty FIFO at or after rr_ptr, wrapping.
    always_comb begin
        logic [RW-1:0] idx;
        idx       = '0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = RW'(rr_wrap(32'(rr_ptr_q), k, NUM_SRC));
            if (!gnt_valid && !empty[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        we_d     = gnt_valid & ~bus.flush;
        waddr_d  = waddr_q;
        rd_d     = rd_q;
        if (bus.flush) begin
            rr_ptr_d = '0;
        end else if (gnt_valid) begin
            rr_ptr_d        = RW'(rr_wrap(32'(gnt_idx), 1, NUM_SRC));
            {waddr_d, rd_d} = head[gnt_idx];
        end
    end

    always_comb begin
        fifo_busy = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            fifo_busy = fifo_busy | (count[i] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            rd_q     <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            rd_q     <= rd_d;
        end
    end

    assign bus.src_ready = ready;
    assign bus.we        = we_q;
    assign bus.waddr     = waddr_q;
    assign bus.rd        = rd_q;
    assign bus.busy      = fifo_busy | we_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (3 sources, 32-bit data, 2-entry FIFOs).
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int NS = 3;
    localparam int W  = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_arbiter_if #(.NUM_SRC(NS), .WIDTH(W), .AW(AW)) bus ();

    wb_arbiter #(
        .NUM_SRC (NS),
        .WIDTH   (W),
        .DEPTH   (32),
        .QDEPTH  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          quota  [NS];
    int          seq    [NS];
    logic [4:0]  base_a [NS];
    logic [31:0] base_d [NS];
    logic        xfer   [NS];

    // Source i presents (base_a+seq, base_d+seq) while quota remains.
    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            bus.src_valid[i]            = (quota[i] > 0);
            bus.src_waddr[i*AW +: AW]   = base_a[i] + 5'(seq[i]);
            bus.src_data[i*W +: W]      = base_d[i] + 32'(seq[i]);
        end
        #1;
        for (int i = 0; i < NS; i++) xfer[i] = bus.src_valid[i] & bus.src_ready[i];
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NS; i++) begin
            if (xfer[i]) begin
                seq[i]++;
                quota[i]--;
            end
        end
        drive();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bus.flush = 1'b0;
        for (int i = 0; i < NS; i++) begin
            quota[i] = 0; seq[i] = 0; base_a[i] = '0; base_d[i] = '0; xfer[i] = 1'b0;
        end
        drive();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL rst_init_we got=%b exp=0", bus.we); end
        n_checks++; if (bus.waddr !== 5'd0) begin n_fail++; $display("FAIL rst_init_waddr got=%0d exp=0", bus.waddr); end
        n_checks++; if (bus.rd !== 32'd0) begin n_fail++; $display("FAIL rst_init_rd got=%h exp=0", bus.rd); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_init_busy got=%b exp=0", bus.busy); end
        n_checks++; if (bus.src_ready !== 3'b111) begin n_fail++; $display("FAIL rst_init_ready got=%b exp=111", bus.src_ready); end
        // Load all sources, then reset mid-cycle while writes are in flight.
        for (int i = 0; i < NS; i++) begin
            quota[i] = 6; base_a[i] = 5'(8 * i + 1); base_d[i] = 32'h7700_0000 + 32'(i << 8);
        end
        drive();
        repeat (3) tick();
        n_checks++; if (bus.we !== 1'b1) begin n_fail++; $display("FAIL rst_pre_we got=%b exp=1", bus.we); end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL rst_async_we got=%b exp=0", bus.we); end
        n_checks++; if (bus.waddr !== 5'd0) begin n_fail++; $display("FAIL rst_async_waddr got=%0d exp=0", bus.waddr); end
        n_checks++; if (bus.rd !== 32'd0) begin n_fail++; $display("FAIL rst_async_rd got=%h exp=0", bus.rd); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy got=%b exp=0", bus.busy); end
        for (int i = 0; i < NS; i++) begin quota[i] = 0; xfer[i] = 1'b0; end
        drive();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (bus.src_ready !== 3'b111) begin n_fail++; $display("FAIL rst_rel_ready got=%b exp=111", bus.src_ready); end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL rst_no_we cyc=%0d got=%b exp=0", c, bus.we); end
        end
    endtask

    task automatic test_single();
        do_reset();
        quota[0] = 1; base_a[0] = 5'd5; base_d[0] = 32'hDEAD_BEEF;
        drive();
        tick();
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL single_e0_we got=%b exp=0", bus.we); end
        tick();
        n_checks++; if (bus.we !== 1'b1) begin n_fail++; $display("FAIL single_we got=%b exp=1", bus.we); end
        n_checks++; if (bus.waddr !== 5'd5) begin n_fail++; $display("FAIL single_waddr got=%0d exp=5", bus.waddr); end
        n_checks++; if (bus.rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_rd got=%h exp=deadbeef", bus.rd); end
        tick();
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle got=%b exp=0", bus.we); end
        n_checks++; if (bus.waddr !== 5'd5) begin n_fail++; $display("FAIL single_hold_waddr got=%0d exp=5", bus.waddr); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  ea;
        logic [31:0] ed;
        do_reset();
        quota[0] = 4; base_a[0] = 5'd9; base_d[0] = 32'hB000_0000;
        drive();
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            ea = 5'd9 + 5'(k);
            ed = 32'hB000_0000 + 32'(k);
            n_checks++; if (bus.we !== 1'b1) begin n_fail++; $display("FAIL b2b_we k=%0d got=%b exp=1", k, bus.we); end
            n_checks++; if (bus.waddr !== ea || bus.rd !== ed) begin
                n_fail++; $display("FAIL b2b_data k=%0d got=%0d/%h exp=%0d/%h", k, bus.waddr, bus.rd, ea, ed);
            end
        end
        tick();
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL b2b_end_we got=%b exp=0", bus.we); end
    endtask

    task automatic test_fairness();
        logic [4:0]  ea;
        logic [31:0] ed;
        int          s, q, guard;
        do_reset();
        for (int i = 0; i < NS; i++) begin
            quota[i] = 3; base_a[i] = 5'(8 * (i + 1)); base_d[i] = 32'hA000_0000 + 32'(i << 8);
        end
        drive();
        tick();
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL fair_e0_we got=%b exp=0", bus.we); end
        // Expected grant order 0,1,2,0,1,2 with per-source sequence numbers 0 then 1.
        for (int c = 0; c < 6; c++) begin
            tick();
            s  = c % 3;
            q  = c / 3;
            ea = 5'(8 * (s + 1) + q);
            ed = 32'hA000_0000 + 32'(s << 8) + 32'(q);
            n_checks++; if (bus.we !== 1'b1 || bus.waddr !== ea || bus.rd !== ed) begin
                n_fail++;
                $display("FAIL fair_grant c=%0d got=%b/%0d/%h exp=1/%0d/%h", c, bus.we, bus.waddr, bus.rd, ea, ed);
            end
        end
        for (int i = 0; i < NS; i++) quota[i] = 0;
        guard = 0;
        while (bus.busy === 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL fair_drain busy=%b exp=0", bus.busy); end
    endtask

    task automatic test_backpressure();
        logic [4:0]  exp_a [6];
        logic [31:0] exp_d [6];
        exp_a = '{5'd20, 5'd1, 5'd21, 5'd2, 5'd22, 5'd3};
        exp_d = '{32'h0000_C000, 32'h1111_0001, 32'h0000_C001,
                  32'h1111_0002, 32'h0000_C002, 32'h1111_0003};
        do_reset();
        quota[0] = 3; base_a[0] = 5'd20; base_d[0] = 32'h0000_C000;
        quota[1] = 3; base_a[1] = 5'd1;  base_d[1] = 32'h1111_0001;
        drive();
        tick();
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL bp_e0_we got=%b exp=0", bus.we); end
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 0) begin
                n_checks++; if (bus.src_ready[1] !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got=%b exp=0", bus.src_ready[1]); end
            end
            if (c == 1) begin
                n_checks++; if (bus.src_ready[1] !== 1'b1) begin n_fail++; $display("FAIL bp_reopen_ready got=%b exp=1", bus.src_ready[1]); end
            end
            n_checks++; if (bus.we !== 1'b1 || bus.waddr !== exp_a[c] || bus.rd !== exp_d[c]) begin
                n_fail++;
                $display("FAIL bp_order c=%0d got=%b/%0d/%h exp=1/%0d/%h", c, bus.we, bus.waddr, bus.rd, exp_a[c], exp_d[c]);
            end
        end
        tick();
        n_checks++; if (bus.we !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_end got=we%b/busy%b exp=0/0", bus.we, bus.busy);
        end
    endtask

    task automatic test_x0_flush();
        do_reset();
        quota[2] = 1; base_a[2] = 5'd0; base_d[2] = 32'h5555_5555;
        drive();
        tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL x0_busy got=%b exp=0", bus.busy); end
        tick();
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL x0_we got=%b exp=0", bus.we); end
        for (int i = 0; i < NS; i++) begin
            quota[i] = 2; seq[i] = 0; base_a[i] = 5'(4 + 8 * i); base_d[i] = 32'hF000_0000 + 32'(i);
        end
        drive();
        tick();
        tick();
        n_checks++; if (bus.we !== 1'b1 || bus.waddr !== 5'd4) begin
            n_fail++; $display("FAIL flush_pre got=%b/%0d exp=1/4", bus.we, bus.waddr);
        end
        bus.flush = 1'b1;
        drive();
        n_checks++; if (bus.src_ready !== 3'b000) begin n_fail++; $display("FAIL flush_ready got=%b exp=000", bus.src_ready); end
        tick();
        bus.flush = 1'b0;
        for (int i = 0; i < NS; i++) quota[i] = 0;
        drive();
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL flush_we got=%b exp=0", bus.we); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%b exp=0", bus.busy); end
        n_checks++; if (bus.src_ready !== 3'b111) begin n_fail++; $display("FAIL flush_ready_after got=%b exp=111", bus.src_ready); end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL flush_stale c=%0d got=%b exp=0", c, bus.we); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fairness();
        test_backpressure();
        test_x0_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
